// File: rtl/bluespec_fifo_axis_downsizer.sv
`default_nettype none
// ============================================================================
// Module  : bluespec_fifo_axis_downsizer
// Brief   : Drains wide Bluespec FIFO entries into narrow AXI-Stream beats,
//           LSB slice first, trimming trailing empty slices.
// Revision: 1.0 - initial release
// ============================================================================
module bluespec_fifo_axis_downsizer #(
   parameter int OUT_BYTES   = 8,
   parameter int RATIO       = 4,
   parameter int ENTRY_WIDTH = OUT_BYTES * RATIO * 9 + 1
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic [ENTRY_WIDTH-1:0] FIFO_D_OUT,
   input  logic                   FIFO_EMPTY_N,
   output logic                   FIFO_DEQ,
   input  logic                   FLUSH,
   output logic                   M_TVALID,
   output logic [OUT_BYTES*8-1:0] M_TDATA,
   output logic [OUT_BYTES-1:0]   M_TKEEP,
   output logic                   M_TLAST,
   input  logic                   M_TREADY
);

   localparam int c_IN_BYTES = OUT_BYTES * RATIO;
   localparam int c_DATA_W   = c_IN_BYTES * 8;
   localparam int c_OUT_W    = OUT_BYTES * 8;
   localparam int c_IDX_W    = $clog2(RATIO);

   logic [c_DATA_W-1:0]   r_data;
   logic [c_IN_BYTES-1:0] r_keep;
   logic                  r_last;
   logic                  r_held;
   logic [c_IDX_W-1:0]    r_idx;
   // Stores nbeats-1 so the reset value of 0 encodes nbeats = 1.
   logic [c_IDX_W-1:0]    r_last_idx;

   logic                  w_last_beat;
   logic                  w_accept;
   logic                  w_load;
   logic [c_IDX_W-1:0]    w_new_last_idx;
   logic [c_OUT_W-1:0]    w_data_sl [RATIO];
   logic [OUT_BYTES-1:0]  w_keep_sl [RATIO];

   generate
      for (genvar g = 0; g < RATIO; g++) begin : g_slice
         assign w_data_sl[g] = r_data[g*c_OUT_W +: c_OUT_W];
         assign w_keep_sl[g] = r_keep[g*OUT_BYTES +: OUT_BYTES];
      end
   endgenerate

   assign w_last_beat = (r_idx == r_last_idx);
   assign w_accept    = r_held & M_TREADY;
   assign w_load      = FIFO_EMPTY_N & ~RST & ~FLUSH & (~r_held | (w_accept & w_last_beat));

   // Highest slice with any keep bit set; an all-zero keep yields a single marker beat.
   always_comb begin
      w_new_last_idx = '0;
      for (int s = 0; s < RATIO; s++) begin
         if (|FIFO_D_OUT[c_DATA_W + s*OUT_BYTES +: OUT_BYTES]) begin
            w_new_last_idx = c_IDX_W'(s);
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_held     <= 1'b0;
         r_idx      <= '0;
         r_last_idx <= '0;
         r_last     <= 1'b0;
         r_data     <= '0;
         r_keep     <= '0;
      end else if (FLUSH) begin
         r_held <= 1'b0;
         r_idx  <= '0;
      end else if (w_load) begin
         r_held     <= 1'b1;
         r_idx      <= '0;
         r_last_idx <= w_new_last_idx;
         r_data     <= FIFO_D_OUT[c_DATA_W-1:0];
         r_keep     <= FIFO_D_OUT[c_DATA_W +: c_IN_BYTES];
         r_last     <= FIFO_D_OUT[ENTRY_WIDTH-1];
      end else if (w_accept) begin
         if (w_last_beat) begin
            r_held <= 1'b0;
         end else begin
            r_idx <= r_idx + c_IDX_W'(1);
         end
      end
   end

   assign FIFO_DEQ = w_load;
   assign M_TVALID = r_held;
   assign M_TDATA  = w_data_sl[r_idx];
   assign M_TKEEP  = w_keep_sl[r_idx];
   assign M_TLAST  = r_held & r_last & w_last_beat;

endmodule
`default_nettype wire

// File: tb/tb_bluespec_fifo_axis_downsizer.sv
`default_nettype none
// ============================================================================
// Module  : tb_bluespec_fifo_axis_downsizer
// Brief   : Self-checking bench with a beat-queue reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_bluespec_fifo_axis_downsizer;

   localparam int c_OB = 8;
   localparam int c_R  = 4;
   localparam int c_IB = c_OB * c_R;
   localparam int c_DW = c_IB * 8;
   localparam int c_EW = c_IB * 9 + 1;

   typedef struct {
      logic [c_OB*8-1:0] data;
      logic [c_OB-1:0]   keep;
      logic              last;
   } beat_t;

   logic              CLK = 1'b0;
   logic              RST = 1'b1;
   logic [c_EW-1:0]   FIFO_D_OUT = '0;
   logic              FIFO_EMPTY_N = 1'b0;
   logic              FIFO_DEQ;
   logic              FLUSH = 1'b0;
   logic              M_TVALID;
   logic [c_OB*8-1:0] M_TDATA;
   logic [c_OB-1:0]   M_TKEEP;
   logic              M_TLAST;
   logic              M_TREADY = 1'b0;

   bluespec_fifo_axis_downsizer #(.OUT_BYTES(c_OB), .RATIO(c_R)) dut (
      .CLK(CLK), .RST(RST), .FIFO_D_OUT(FIFO_D_OUT), .FIFO_EMPTY_N(FIFO_EMPTY_N),
      .FIFO_DEQ(FIFO_DEQ), .FLUSH(FLUSH), .M_TVALID(M_TVALID), .M_TDATA(M_TDATA),
      .M_TKEEP(M_TKEEP), .M_TLAST(M_TLAST), .M_TREADY(M_TREADY)
   );

   always #5 CLK = ~CLK;

   int errors = 0;
   int checks = 0;
   logic [c_EW-1:0] in_q[$];
   beat_t           exp_q[$];
   bit              allow = 1'b1;

   logic              s_deq, s_valid, s_last;
   logic [c_OB*8-1:0] s_data;
   logic [c_OB-1:0]   s_keep;
   bit                prev_stall = 1'b0;
   beat_t             prev_beat;

   function automatic logic [c_EW-1:0] make_entry(input logic last, input logic [c_IB-1:0] keep);
      logic [c_EW-1:0] e;
      e = '0;
      for (int w = 0; w < c_DW / 32; w++) e[w*32 +: 32] = $urandom;
      e[c_DW +: c_IB] = keep;
      e[c_EW-1]       = last;
      return e;
   endfunction

   // Reference: one beat per slice up to the highest non-empty slice, minimum one.
   task automatic push_beats(input logic [c_EW-1:0] e);
      logic [c_IB-1:0] keep;
      int n;
      beat_t b;
      keep = e[c_DW +: c_IB];
      n = 1;
      for (int s = 0; s < c_R; s++) if (keep[s*c_OB +: c_OB] != 0) n = s + 1;
      for (int s = 0; s < n; s++) begin
         b.data = e[s*c_OB*8 +: c_OB*8];
         b.keep = keep[s*c_OB +: c_OB];
         b.last = e[c_EW-1] && (s == n - 1);
         exp_q.push_back(b);
      end
   endtask

   function automatic logic [c_OB*8-1:0] slice_of(input logic [c_EW-1:0] e, input int s);
      return e[s*c_OB*8 +: c_OB*8];
   endfunction

   // One clock: drive FIFO head at negedge, sample, score, advance the model at posedge.
   task automatic cycle();
      beat_t b;
      FIFO_EMPTY_N = allow && (in_q.size() > 0);
      FIFO_D_OUT   = (in_q.size() > 0) ? in_q[0] : '0;
      #1;
      s_deq = FIFO_DEQ; s_valid = M_TVALID; s_data = M_TDATA;
      s_keep = M_TKEEP; s_last = M_TLAST;
      if (!FIFO_EMPTY_N) begin
         checks++;
         if (s_deq !== 1'b0) begin errors++; $display("FAIL deq_while_empty: got %b want 0", s_deq); end
      end
      if (prev_stall && s_valid) begin
         checks++;
         if (s_data !== prev_beat.data || s_keep !== prev_beat.keep || s_last !== prev_beat.last) begin
            errors++;
            $display("FAIL stall_stability: got %h/%h/%b want %h/%h/%b", s_data, s_keep, s_last,
                     prev_beat.data, prev_beat.keep, prev_beat.last);
         end
      end
      if (s_valid === 1'b1 && M_TREADY && !RST && !FLUSH) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++; $display("FAIL unexpected_beat: got %h want none", s_data);
         end else begin
            b = exp_q.pop_front();
            if (s_data !== b.data || s_keep !== b.keep || s_last !== b.last) begin
               errors++;
               $display("FAIL beat: got %h/%h/%b want %h/%h/%b", s_data, s_keep, s_last, b.data, b.keep, b.last);
            end
         end
      end
      prev_stall = s_valid && !M_TREADY && !RST && !FLUSH;
      prev_beat.data = s_data; prev_beat.keep = s_keep; prev_beat.last = s_last;
      @(posedge CLK);
      if (RST || FLUSH) exp_q.delete();
      if (s_deq === 1'b1 && in_q.size() > 0) push_beats(in_q.pop_front());
      @(negedge CLK);
   endtask

   task automatic drain();
      int n;
      M_TREADY = 1'b1; allow = 1'b1; n = 0;
      while ((in_q.size() > 0 || exp_q.size() > 0 || M_TVALID) && n < 2000) begin
         cycle(); n++;
      end
      checks++;
      if (n >= 2000) begin errors++; $display("FAIL drain_timeout: got %0d cycles want <2000", n); end
   endtask

   task automatic test_reset();
      in_q.push_back(make_entry(1'b1, '1));
      RST = 1'b1; M_TREADY = 1'b1;
      cycle();
      checks++;
      if (s_deq !== 1'b0) begin errors++; $display("FAIL reset_deq: got %b want 0", s_deq); end
      cycle();
      RST = 1'b0;
      cycle();
      checks++;
      if (s_valid !== 1'b0 || s_last !== 1'b0) begin
         errors++; $display("FAIL reset_outputs: got valid=%b last=%b want 0/0", s_valid, s_last);
      end
      checks++;
      if (s_deq !== 1'b1) begin errors++; $display("FAIL reset_first_deq: got %b want 1", s_deq); end
      drain();
   endtask

   task automatic test_full_entry();
      logic [c_EW-1:0] a;
      a = make_entry(1'b0, '1);
      in_q.push_back(a);
      M_TREADY = 1'b1;
      cycle();
      checks++;
      if (s_deq !== 1'b1 || s_valid !== 1'b0) begin
         errors++; $display("FAIL full_deq: got deq=%b valid=%b want 1/0", s_deq, s_valid);
      end
      for (int i = 0; i < c_R; i++) begin
         cycle();
         checks++;
         if (s_valid !== 1'b1 || s_data !== slice_of(a, i) || s_keep !== 8'hFF || s_last !== 1'b0 || s_deq !== 1'b0) begin
            errors++;
            $display("FAIL full_beat%0d: got v=%b d=%h k=%h l=%b deq=%b want 1/%h/ff/0/0",
                     i, s_valid, s_data, s_keep, s_last, s_deq, slice_of(a, i));
         end
      end
      cycle();
      checks++;
      if (s_valid !== 1'b0) begin errors++; $display("FAIL full_idle: got %b want 0", s_valid); end
   endtask

   task automatic test_back_to_back();
      logic [c_EW-1:0] a, b;
      a = make_entry(1'b0, '1);
      b = make_entry(1'b1, 32'h0000_3FFF);
      in_q.push_back(a); in_q.push_back(b);
      M_TREADY = 1'b1;
      cycle();
      for (int i = 0; i < c_R; i++) begin
         cycle();
         checks++;
         if (s_valid !== 1'b1 || s_data !== slice_of(a, i) || s_deq !== (i == c_R - 1)) begin
            errors++;
            $display("FAIL b2b_a%0d: got v=%b d=%h deq=%b want 1/%h/%b", i, s_valid, s_data, s_deq,
                     slice_of(a, i), (i == c_R - 1));
         end
      end
      cycle();
      checks++;
      if (s_valid !== 1'b1 || s_data !== slice_of(b, 0) || s_keep !== 8'hFF || s_last !== 1'b0) begin
         errors++; $display("FAIL b2b_b0: got v=%b k=%h l=%b want 1/ff/0", s_valid, s_keep, s_last);
      end
      cycle();
      checks++;
      if (s_valid !== 1'b1 || s_data !== slice_of(b, 1) || s_keep !== 8'h3F || s_last !== 1'b1) begin
         errors++; $display("FAIL b2b_b1: got v=%b k=%h l=%b want 1/3f/1", s_valid, s_keep, s_last);
      end
      cycle();
      checks++;
      if (s_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b want 0", s_valid); end
   endtask

   task automatic test_zero_keep();
      logic [c_EW-1:0] n;
      n = make_entry(1'b1, '1);
      in_q.push_back(make_entry(1'b1, '0)); in_q.push_back(n);
      M_TREADY = 1'b1;
      cycle();
      cycle();
      checks++;
      if (s_valid !== 1'b1 || s_keep !== 8'h00 || s_last !== 1'b1 || s_deq !== 1'b1) begin
         errors++; $display("FAIL zero_keep: got v=%b k=%h l=%b deq=%b want 1/00/1/1", s_valid, s_keep, s_last, s_deq);
      end
      cycle();
      checks++;
      if (s_valid !== 1'b1 || s_data !== slice_of(n, 0)) begin
         errors++; $display("FAIL zero_next: got v=%b d=%h want 1/%h", s_valid, s_data, slice_of(n, 0));
      end
      drain();
   endtask

   task automatic test_flush();
      logic [c_EW-1:0] a, b;
      a = make_entry(1'b0, '1);
      b = make_entry(1'b1, '1);
      in_q.push_back(a); in_q.push_back(b);
      M_TREADY = 1'b1;
      cycle(); cycle(); cycle();
      M_TREADY = 1'b0; FLUSH = 1'b1;
      cycle();
      checks++;
      if (s_valid !== 1'b1 || s_data !== slice_of(a, 2) || s_deq !== 1'b0) begin
         errors++; $display("FAIL flush_cycle: got v=%b d=%h deq=%b want 1/%h/0", s_valid, s_data, s_deq, slice_of(a, 2));
      end
      FLUSH = 1'b0;
      cycle();
      checks++;
      if (s_valid !== 1'b0 || s_deq !== 1'b1) begin
         errors++; $display("FAIL flush_after: got v=%b deq=%b want 0/1", s_valid, s_deq);
      end
      M_TREADY = 1'b1;
      cycle();
      checks++;
      if (s_valid !== 1'b1 || s_data !== slice_of(b, 0)) begin
         errors++; $display("FAIL flush_restart: got v=%b d=%h want 1/%h", s_valid, s_data, slice_of(b, 0));
      end
      drain();
   endtask

   task automatic test_reset_mid();
      logic [c_EW-1:0] a, b;
      a = make_entry(1'b0, '1);
      b = make_entry(1'b1, '1);
      in_q.push_back(a); in_q.push_back(b);
      M_TREADY = 1'b1;
      cycle(); cycle();
      RST = 1'b1;
      cycle();
      checks++;
      if (s_deq !== 1'b0) begin errors++; $display("FAIL rstmid_deq: got %b want 0", s_deq); end
      RST = 1'b0;
      cycle();
      checks++;
      if (s_valid !== 1'b0 || s_deq !== 1'b1) begin
         errors++; $display("FAIL rstmid_after: got v=%b deq=%b want 0/1", s_valid, s_deq);
      end
      cycle();
      checks++;
      if (s_valid !== 1'b1 || s_data !== slice_of(b, 0)) begin
         errors++; $display("FAIL rstmid_restart: got v=%b d=%h want 1/%h", s_valid, s_data, slice_of(b, 0));
      end
      drain();
   endtask

   task automatic test_random();
      int produced, n;
      logic [c_IB-1:0] keep;
      produced = 0; n = 0;
      while ((produced < 100 || in_q.size() > 0 || exp_q.size() > 0) && n < 5000) begin
         if (produced < 100 && in_q.size() < 2 && $urandom_range(0, 3) != 0) begin
            case ($urandom_range(0, 3))
               0:       keep = '1;
               1:       keep = '0;
               2:       keep = {c_IB{1'b1}} >> $urandom_range(0, c_IB - 1);
               default: keep = $urandom;
            endcase
            in_q.push_back(make_entry(1'($urandom_range(0, 1)), keep));
            produced++;
         end
         M_TREADY = 1'($urandom_range(0, 1));
         allow    = ($urandom_range(0, 4) != 0);
         cycle();
         n++;
      end
      checks++;
      if (n >= 5000) begin errors++; $display("FAIL random_timeout: got %0d cycles want <5000", n); end
      drain();
   endtask

   initial begin
      @(negedge CLK);
      test_reset();
      test_full_entry();
      test_back_to_back();
      test_zero_keep();
      test_flush();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
